hier_child_sequencer: RTL
=========================

// Module: hier_child_sequencer
// PURPOSE
//   Parametrised hierarchy node. It launches up to NUM_CHILDREN child sub-blocks and collects their
//   completion. It generalises the fixed 5-child structural node with an enable mask, a runtime
//   parallel/sequential mode, a per-wait timeout and status reporting.
//   Sits between a parent node's start/done handshake and its children's start/done handshakes,
//   so nodes chain recursively.
// PARAMETERS
//   NUM_CHILDREN  5   number of child handshake lanes (1..32)
//   TIMEOUT_W     16  width of timeout counter / timeout_cycles_i
//   IDX_W         $clog2(NUM_CHILDREN) (min 1)  width of child index outputs
// PORTS
//   clk               in   1             single clock, rising edge
//   rst               in   1             synchronous reset, active-high
//   start_i           in   1             parent start pulse (sampled only in IDLE)
//   mode_i            in   1             0 = parallel, 1 = sequential (latched on start)
//   en_mask_i         in   NUM_CHILDREN  children to run (latched on start)
//   timeout_cycles_i  in   TIMEOUT_W     max wait cycles per wait phase; 0 = no timeout (latched)
//   child_done_i      in   NUM_CHILDREN  child completion pulses
//   child_start_o     out  NUM_CHILDREN  child start pulses, one cycle wide
//   busy_o            out  1             high from cycle after accepted start until done/error pulse
//   done_o            out  1             one-cycle pulse, all enabled children finished
//   error_o           out  1             one-cycle pulse, timeout expired
//   done_mask_o       out  NUM_CHILDREN  sticky completion bits of current/last run
//   err_idx_o         out  IDX_W         child index that timed out (valid with/after error_o)
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, latched mask/mode/timeout=0, timer=0. Reset mid-run aborts
//     immediately; child_start_o is 0 in the cycle after rst; no done/error is emitted.
//   FSM states: IDLE, PAR_LAUNCH, PAR_WAIT, SEQ_LAUNCH, SEQ_WAIT, DONE, ERR.
//   IDLE:
//     - On start_i: latch inputs, clear done_mask_o and err_idx_o.
//     - en_mask_i==0 -> DONE.
//     - Otherwise mode 0 -> PAR_LAUNCH; mode 1 -> SEQ_LAUNCH with idx = lowest set mask bit.
//   PAR_LAUNCH: child_start_o = mask for exactly one cycle -> PAR_WAIT. Timer cleared.
//   PAR_WAIT:
//     - Each cycle, done_mask_o |= child_done_i & mask. Done pulses from disabled lanes are ignored.
//     - When the updated done_mask equals mask -> DONE.
//     - Else timer++. If timeout != 0 and timer reaches timeout -> ERR, with
//       err_idx_o = lowest enabled lane not yet done.
//     - Completion has priority over timeout in the same cycle.
//   SEQ_LAUNCH: child_start_o[idx] = 1 for one cycle -> SEQ_WAIT. Timer cleared.
//   SEQ_WAIT:
//     - Only child_done_i[idx] is honoured; it sets done_mask_o[idx].
//     - If no higher set mask bit remains -> DONE. Else idx = next higher set bit -> SEQ_LAUNCH.
//     - Timeout rule is identical to PAR_WAIT, applied per child; err_idx_o = idx.
//   child_done_i in a LAUNCH cycle (same cycle as child_start_o) is ignored.
//   DONE: done_o=1 for one cycle -> IDLE.
//   ERR: error_o=1 for one cycle -> IDLE. done_mask_o keeps its partial value.
//   done_o and error_o are never high together. done_mask_o and err_idx_o hold until the next
//     accepted start.
//   busy_o = (state != IDLE) && (state != DONE) && (state != ERR).
//   start_i while not IDLE (including the DONE/ERR cycle) is ignored; it is not queued.
//   Latency:
//     - Parallel: start at cycle 0 -> child_start at cycle 1; last done at cycle k -> done_o at k+1.
//     - Sequential: each child adds 1 launch cycle plus its wait.
//     - Empty mask: start at cycle 0 -> done_o at cycle 1, child_start_o never asserted.
//   Timer: TIMEOUT_W bits, saturates, never wraps.
// TESTING
//   T1 Parallel, mask=5'b11111, timeout=0; children respond 3,5,2,7,4 cycles after start
//      -> one child_start_o=5'b11111 pulse; done_o 1 cycle after the 7-cycle child; done_mask_o=5'b11111.
//   T2 Sequential, mask=5'b10110; each child responds after 2 cycles
//      -> child_start_o pulses on bits 1,2,4 in order, never 0 or 3; done_o once; done_mask_o=5'b10110.
//   T3 Parallel, mask=5'b00011, timeout=10; only child 0 responds
//      -> error_o 10 cycles into PAR_WAIT; err_idx_o=1; done_mask_o=5'b00001; no done_o.
//   T4 Empty mask=0, any mode -> done_o at cycle 1; child_start_o stays 0; busy_o stays 0.
//   T5 start_i re-asserted while busy, plus child_done_i on disabled lane 3 (mask=5'b00001)
//      -> no second launch; lane 3 not in done_mask_o; run completes normally.
//   T6 rst asserted during SEQ_WAIT of child 2 -> next cycle all outputs 0, state IDLE;
//      new start after rst runs cleanly from the lowest mask bit.

Source files
------------

// File: rtl/hier_child_sequencer.sv
// Hierarchy node: launches enabled child blocks in parallel or in ascending index order,
// collects their done pulses and reports completion, or a timeout together with the offending lane.
module hier_child_sequencer #(
    parameter int NUM_CHILDREN = 5,
    parameter int TIMEOUT_W    = 16,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [NUM_CHILDREN-1:0] en_mask_i,
    input  logic [TIMEOUT_W-1:0]    timeout_cycles_i,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [NUM_CHILDREN-1:0] done_mask_o,
    output logic [IDX_W-1:0]        err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PAR_LAUNCH, S_PAR_WAIT, S_SEQ_LAUNCH, S_SEQ_WAIT, S_DONE, S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic [TIMEOUT_W-1:0]    timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHILDREN-1:0] done_mask_q, done_mask_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;
    logic [NUM_CHILDREN-1:0] child_start_q, child_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic [NUM_CHILDREN-1:0] merged;
    logic [NUM_CHILDREN-1:0] remaining;
    logic [TIMEOUT_W-1:0]    timer_inc;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CHILDREN-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_CHILDREN - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_CHILDREN-1:0] lanes_above(input logic [IDX_W-1:0] idx);
        logic [NUM_CHILDREN-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (i > int'(idx)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Wait timer saturates instead of wrapping so a huge timeout can never alias to a small one.
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        timeout_d   = timeout_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        done_mask_d = done_mask_q;
        err_idx_d   = err_idx_q;
        merged      = done_mask_q | (child_done_i & mask_q);
        remaining   = mask_q & lanes_above(idx_q);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d      = en_mask_i;
                    timeout_d   = timeout_cycles_i;
                    timer_d     = '0;
                    done_mask_d = '0;
                    err_idx_d   = '0;
                    if (en_mask_i == '0) begin
                        state_d = S_DONE;
                    end else if (!mode_i) begin
                        state_d = S_PAR_LAUNCH;
                    end else begin
                        state_d = S_SEQ_LAUNCH;
                        idx_d   = lowest_set(en_mask_i);
                    end
                end
            end
            S_PAR_LAUNCH: begin
                timer_d = '0;
                state_d = S_PAR_WAIT;
            end
            S_PAR_WAIT: begin
                done_mask_d = merged;
                if (merged == mask_q) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_inc;
                    if (timeout_q != '0 && timer_inc == timeout_q) begin
                        state_d   = S_ERR;
                        err_idx_d = lowest_set(mask_q & ~merged);
                    end
                end
            end
            S_SEQ_LAUNCH: begin
                timer_d = '0;
                state_d = S_SEQ_WAIT;
            end
            S_SEQ_WAIT: begin
                if (child_done_i[idx_q]) begin
                    done_mask_d[idx_q] = 1'b1;
                    if (remaining == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = lowest_set(remaining);
                        state_d = S_SEQ_LAUNCH;
                    end
                end else begin
                    timer_d = timer_inc;
                    if (timeout_q != '0 && timer_inc == timeout_q) begin
                        state_d   = S_ERR;
                        err_idx_d = idx_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered in that state's cycle.
        child_start_d = '0;
        if (state_d == S_PAR_LAUNCH) child_start_d = mask_d;
        if (state_d == S_SEQ_LAUNCH) child_start_d = NUM_CHILDREN'(1) << idx_d;
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            timeout_q     <= '0;
            timer_q       <= '0;
            idx_q         <= '0;
            done_mask_q   <= '0;
            err_idx_q     <= '0;
            child_start_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            timeout_q     <= timeout_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            done_mask_q   <= done_mask_d;
            err_idx_q     <= err_idx_d;
            child_start_q <= child_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign child_start_o = child_start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign done_mask_o   = done_mask_q;
    assign err_idx_o     = err_idx_q;

endmodule
